// File: rtl/reward_pkg.sv
// Shared definitions for the reward scheduler and its neighbours.
// Contents:
//   DEF_*          default widths / depths / watchdog limit
//   sched_state_t  scheduler FSM state encoding
//   PKT_*          packet-type codes carried on pktType to the datapath
package reward_pkg;

    localparam int DEF_WORD_WIDTH    = 16;
    localparam int DEF_MAX_NEIGHBORS = 16;
    localparam int DEF_TIMEOUT       = 64;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_WAIT_RD   = 3'd2,
        S_COMPUTE   = 3'd3,
        S_WRITEBACK = 3'd4,
        S_DONE      = 3'd5
    } sched_state_t;

    localparam logic [2:0] PKT_DATA        = 3'd0;
    localparam logic [2:0] PKT_HELLO       = 3'd1;
    localparam logic [2:0] PKT_ACK         = 3'd2;
    localparam logic [2:0] PKT_ROUTE_REQ   = 3'd3;
    localparam logic [2:0] PKT_ROUTE_REPLY = 3'd4;

endpackage

// File: rtl/reward_scheduler_if.sv
// Bus between the reward scheduler, the neighbor table and the reward datapath.
//   nt_rd_en/nt_rd_addr        table read request (scheduler -> table)
//   nt_rd_valid/mNodeID/mNodeQValue  read response (table -> scheduler)
//   rw_start                   datapath launch pulse (scheduler -> datapath)
//   rw_done/rw_qvalue          datapath result (datapath -> scheduler)
//   wb_en/wb_addr/wb_qvalue    table write-back (scheduler -> table)
// Modports: master = scheduler side, slave = table/datapath side.
interface reward_scheduler_if
    import reward_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int IDX_W      = $clog2(DEF_MAX_NEIGHBORS)
);
    logic                  nt_rd_en;
    logic [IDX_W-1:0]      nt_rd_addr;
    logic                  nt_rd_valid;
    logic [WORD_WIDTH-1:0] mNodeID;
    logic [WORD_WIDTH-1:0] mNodeQValue;
    logic                  rw_start;
    logic                  rw_done;
    logic [WORD_WIDTH-1:0] rw_qvalue;
    logic                  wb_en;
    logic [IDX_W-1:0]      wb_addr;
    logic [WORD_WIDTH-1:0] wb_qvalue;

    modport master (
        output nt_rd_en, nt_rd_addr, rw_start, wb_en, wb_addr, wb_qvalue,
        input  nt_rd_valid, mNodeID, mNodeQValue, rw_done, rw_qvalue
    );

    modport slave (
        input  nt_rd_en, nt_rd_addr, rw_start, wb_en, wb_addr, wb_qvalue,
        output nt_rd_valid, mNodeID, mNodeQValue, rw_done, rw_qvalue
    );
endinterface

// File: rtl/watchdog_counter.sv
// Response watchdog for handshake controllers.
//   clk, nrst  clock, synchronous active-low reset
//   clear      restart the count (asserted on the edge entering a waiting state)
//   enable     count while the owner is waiting for a response
//   expired    high in the TIMEOUT-th enabled cycle after the last clear
module watchdog_counter #(
    parameter int TIMEOUT = 64
) (
    input  logic clk,
    input  logic nrst,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // count_q is 0 in the first waiting cycle, so TIMEOUT-1 marks the last one.
    assign expired = enable && (count_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/reward_scheduler.sv
// Walks the neighbor table after a qualifying packet: reads each entry, runs
// one reward computation, writes the new Q back and keeps the best neighbor.
//   clk, nrst                 clock, synchronous active-low reset
//   start, fPacketType, neighborCount   scan request (accepted only when idle)
//   busy, done, err           scan status (done is a one-cycle pulse)
//   pktType                   latched packet type for the datapath
//   bus                       table read/write and datapath handshake
//   chosenHop/chosenQ/chosenValid       best (highest Q) neighbor so far
module reward_scheduler
    import reward_pkg::*;
#(
    parameter int WORD_WIDTH    = DEF_WORD_WIDTH,
    parameter int MAX_NEIGHBORS = DEF_MAX_NEIGHBORS,
    parameter int TIMEOUT       = DEF_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  start,
    input  logic [2:0]            fPacketType,
    input  logic [4:0]            neighborCount,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [2:0]            pktType,
    reward_scheduler_if.master    bus,
    output logic [WORD_WIDTH-1:0] chosenHop,
    output logic [WORD_WIDTH-1:0] chosenQ,
    output logic                  chosenValid
);
    localparam int IDX_W = $clog2(MAX_NEIGHBORS);
    localparam int CNT_W = IDX_W + 1;

    sched_state_t          state_q, state_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [2:0]            pkt_type_q, pkt_type_d;
    logic [WORD_WIDTH-1:0] node_id_q, node_id_d;
    logic [WORD_WIDTH-1:0] node_q_q, node_q_d;
    logic [WORD_WIDTH-1:0] new_q_q, new_q_d;
    logic [WORD_WIDTH-1:0] chosen_hop_q, chosen_hop_d;
    logic [WORD_WIDTH-1:0] chosen_q_q, chosen_q_d;
    logic                  chosen_valid_q, chosen_valid_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  nt_rd_en_q, nt_rd_en_d;
    logic                  rw_start_q, rw_start_d;
    logic                  wb_en_q, wb_en_d;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    // The table's stored Q is captured with the ID as one entry snapshot; the
    // ranking itself only uses the freshly computed Q.
    logic unused_read_q;
    assign unused_read_q = ^node_q_q;

    // Restart on every state change so each wait gets its own full budget.
    assign wd_clear  = (state_d != state_q);
    assign wd_enable = (state_q == S_WAIT_RD) || (state_q == S_COMPUTE);

    watchdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        n_d            = n_q;
        pkt_type_d     = pkt_type_q;
        node_id_d      = node_id_q;
        node_q_d       = node_q_q;
        new_q_d        = new_q_q;
        chosen_hop_d   = chosen_hop_q;
        chosen_q_d     = chosen_q_q;
        chosen_valid_d = chosen_valid_q;
        err_d          = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pkt_type_d     = fPacketType;
                    if (32'(neighborCount) > 32'(MAX_NEIGHBORS)) begin
                        n_d = CNT_W'(MAX_NEIGHBORS);
                    end else begin
                        n_d = CNT_W'(neighborCount);
                    end
                    idx_d          = '0;
                    chosen_hop_d   = '0;
                    chosen_q_d     = '0;
                    chosen_valid_d = 1'b0;
                    err_d          = 1'b0;
                    state_d        = (n_d == '0) ? S_DONE : S_READ;
                end
            end
            S_READ: begin
                state_d = S_WAIT_RD;
            end
            S_WAIT_RD: begin
                if (bus.nt_rd_valid) begin
                    node_id_d = bus.mNodeID;
                    node_q_d  = bus.mNodeQValue;
                    state_d   = S_COMPUTE;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_COMPUTE: begin
                // rw_done coinciding with our own launch pulse is stale.
                if (bus.rw_done && !rw_start_q) begin
                    new_q_d = bus.rw_qvalue;
                    state_d = S_WRITEBACK;
                end else if (wd_expired) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_WRITEBACK: begin
                // Strict compare: on a tie the earlier (lower index) entry stays.
                if (!chosen_valid_q || (new_q_q > chosen_q_q)) begin
                    chosen_hop_d   = node_id_q;
                    chosen_q_d     = new_q_q;
                    chosen_valid_d = 1'b1;
                end
                if ({1'b0, idx_q} == n_q - 1'b1) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_READ;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered from the next state so they line up with it.
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        nt_rd_en_d = (state_d == S_READ);
        rw_start_d = (state_d == S_COMPUTE) && (state_q != S_COMPUTE);
        wb_en_d    = (state_d == S_WRITEBACK);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q        <= S_IDLE;
            idx_q          <= '0;
            n_q            <= '0;
            pkt_type_q     <= '0;
            node_id_q      <= '0;
            node_q_q       <= '0;
            new_q_q        <= '0;
            chosen_hop_q   <= '0;
            chosen_q_q     <= '0;
            chosen_valid_q <= 1'b0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            nt_rd_en_q     <= 1'b0;
            rw_start_q     <= 1'b0;
            wb_en_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            n_q            <= n_d;
            pkt_type_q     <= pkt_type_d;
            node_id_q      <= node_id_d;
            node_q_q       <= node_q_d;
            new_q_q        <= new_q_d;
            chosen_hop_q   <= chosen_hop_d;
            chosen_q_q     <= chosen_q_d;
            chosen_valid_q <= chosen_valid_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
            done_q         <= done_d;
            nt_rd_en_q     <= nt_rd_en_d;
            rw_start_q     <= rw_start_d;
            wb_en_q        <= wb_en_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign pktType        = pkt_type_q;
    assign chosenHop      = chosen_hop_q;
    assign chosenQ        = chosen_q_q;
    assign chosenValid    = chosen_valid_q;
    assign bus.nt_rd_en   = nt_rd_en_q;
    assign bus.nt_rd_addr = idx_q;
    assign bus.rw_start   = rw_start_q;
    assign bus.wb_en      = wb_en_q;
    assign bus.wb_addr    = idx_q;
    assign bus.wb_qvalue  = new_q_q;
endmodule

// File: tb/tb_reward_scheduler.sv
// Self-checking bench for reward_scheduler: behavioural neighbor table and
// reward datapath responders, a write-back scoreboard, one task per scenario.
module tb_reward_scheduler;
    import reward_pkg::*;

    localparam int WW    = 16;
    localparam int MAXN  = 16;
    localparam int TO    = 64;
    localparam int IDX_W = 4;
    localparam logic [WW-1:0] ID_BASE = 16'h0A00;

    typedef struct packed {
        logic [IDX_W-1:0] addr;
        logic [WW-1:0]    q;
    } wb_exp_t;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          start = 1'b0;
    logic [2:0]    fPacketType = 3'd0;
    logic [4:0]    neighborCount = 5'd0;
    logic          busy, done, err, chosenValid;
    logic [2:0]    pktType;
    logic [WW-1:0] chosenHop, chosenQ;

    reward_scheduler_if #(.WORD_WIDTH(WW), .IDX_W(IDX_W)) bus ();

    reward_scheduler #(
        .WORD_WIDTH    (WW),
        .MAX_NEIGHBORS (MAXN),
        .TIMEOUT       (TO)
    ) dut (
        .clk           (clk),
        .nrst          (nrst),
        .start         (start),
        .fPacketType   (fPacketType),
        .neighborCount (neighborCount),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .pktType       (pktType),
        .bus           (bus),
        .chosenHop     (chosenHop),
        .chosenQ       (chosenQ),
        .chosenValid   (chosenValid)
    );

    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    int checks = 0;
    int errors = 0;

    // Responder knobs
    int          rd_delay  = 1;
    int          rw_delay  = 1;
    bit          stray_en  = 1'b0;
    int          hang_addr = -1;
    int          last_rd_addr = 0;
    logic [WW-1:0] rw_vals [MAXN];

    wb_exp_t exp_wb[$];

    // Per-scan observations
    bit          scan_active = 1'b0;
    int          start_edge = 0;
    int          done_cnt, done_cycle, wb_cnt, rw_cnt, busy_first, busy_last;
    int          last_wb_addr;
    logic [IDX_W-1:0] rd_addrs[$];
    logic [WW-1:0] done_hop, done_q;
    logic          done_valid, done_err;

    // Neighbor table: answers a read after rd_delay cycles.
    initial begin
        bus.nt_rd_valid = 1'b0;
        bus.mNodeID     = '0;
        bus.mNodeQValue = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.nt_rd_en === 1'b1) begin
                last_rd_addr = int'(bus.nt_rd_addr);
                repeat (rd_delay) @(posedge clk);
                #1;
                bus.nt_rd_valid = 1'b1;
                bus.mNodeID     = ID_BASE + 16'(last_rd_addr);
                bus.mNodeQValue = 16'h5000 + 16'(last_rd_addr);
                @(posedge clk); #1;
                bus.nt_rd_valid = 1'b0;
            end
        end
    end

    // Reward datapath: optional stray done in the launch cycle, then the real
    // result after rw_delay cycles unless this entry is set to hang.
    initial begin
        int addr_i;
        bus.rw_done   = 1'b0;
        bus.rw_qvalue = '0;
        forever begin
            @(posedge clk); #1;
            if (bus.rw_start === 1'b1) begin
                addr_i = last_rd_addr;
                if (stray_en) begin
                    bus.rw_done   = 1'b1;
                    bus.rw_qvalue = 16'hDEAD;
                end
                @(posedge clk); #1;
                bus.rw_done = 1'b0;
                if (addr_i != hang_addr) begin
                    repeat (rw_delay - 1) begin
                        @(posedge clk); #1;
                    end
                    bus.rw_done   = 1'b1;
                    bus.rw_qvalue = rw_vals[addr_i];
                    exp_wb.push_back(wb_exp_t'{IDX_W'(addr_i), rw_vals[addr_i]});
                    @(posedge clk); #1;
                    bus.rw_done = 1'b0;
                end
            end
        end
    end

    // Monitor: records scan events and checks each write-back against the scoreboard.
    initial begin
        int cyc;
        wb_exp_t e;
        forever begin
            @(negedge clk);
            if (scan_active) begin
                cyc = edge_cnt - start_edge;
                if (busy === 1'b1) begin
                    if (busy_first < 0) busy_first = cyc;
                    busy_last = cyc;
                end
                if (bus.nt_rd_en === 1'b1) rd_addrs.push_back(bus.nt_rd_addr);
                if (bus.rw_start === 1'b1) rw_cnt++;
                if (bus.wb_en === 1'b1) begin
                    wb_cnt++;
                    last_wb_addr = int'(bus.wb_addr);
                    checks++;
                    if (exp_wb.size() == 0) begin
                        errors++;
                        $display("FAIL wb_unexpected: got addr %0d q %0d, required no write-back",
                                 bus.wb_addr, bus.wb_qvalue);
                    end else begin
                        e = exp_wb.pop_front();
                        if (bus.wb_addr !== e.addr || bus.wb_qvalue !== e.q) begin
                            errors++;
                            $display("FAIL wb_data: got addr %0d q %0d, required addr %0d q %0d",
                                     bus.wb_addr, bus.wb_qvalue, e.addr, e.q);
                        end else begin
                            $display("wb   addr %0d q %0d at cycle %0d", bus.wb_addr, bus.wb_qvalue, cyc);
                        end
                    end
                end
                if (done === 1'b1) begin
                    done_cnt++;
                    done_cycle = cyc;
                    done_hop   = chosenHop;
                    done_q     = chosenQ;
                    done_valid = chosenValid;
                    done_err   = err;
                    $display("done cycle %0d hop %h q %0d valid %0d err %0d",
                             cyc, chosenHop, chosenQ, chosenValid, err);
                end
            end
        end
    end

    task automatic do_start(input logic [4:0] cnt, input logic [2:0] ty);
        @(negedge clk);
        done_cnt = 0; done_cycle = -1; wb_cnt = 0; rw_cnt = 0;
        busy_first = -1; busy_last = -1; last_wb_addr = -1;
        rd_addrs.delete();
        start = 1'b1; neighborCount = cnt; fPacketType = ty;
        @(posedge clk); #1;
        start_edge  = edge_cnt - 1;
        scan_active = 1'b1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles);
        int n = 0;
        while (done_cnt == 0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL done_timeout: got no done within %0d cycles, required one pulse", max_cycles);
        end
    endtask

    task automatic test_reset();
        logic [65:0] outs;
        nrst = 1'b0;
        repeat (3) @(negedge clk);
        outs = {busy, done, err, pktType, chosenValid, chosenHop, chosenQ, bus.nt_rd_en,
                bus.nt_rd_addr, bus.rw_start, bus.wb_en, bus.wb_addr, bus.wb_qvalue};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got %h, required 0", outs);
        end
        nrst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy %b done %b, required 0 0", busy, done);
        end
        $display("reset checked");
    endtask

    task automatic test_three_entries();
        rw_vals[0] = 16'd10; rw_vals[1] = 16'd30; rw_vals[2] = 16'd30;
        do_start(5'd3, PKT_HELLO);
        wait_done(100);
        checks++;
        if (done_cycle != 16) begin errors++; $display("FAIL n3_done_cycle: got %0d, required 16", done_cycle); end
        checks++;
        if (done_hop !== ID_BASE + 16'd1 || done_q !== 16'd30 || done_valid !== 1'b1) begin
            errors++;
            $display("FAIL n3_chosen: got hop %h q %0d v %b, required hop %h q 30 v 1",
                     done_hop, done_q, done_valid, ID_BASE + 16'd1);
        end
        checks++;
        if (rd_addrs.size() != 3 || rd_addrs[0] !== 4'd0 || rd_addrs[1] !== 4'd1 || rd_addrs[2] !== 4'd2) begin
            errors++;
            $display("FAIL n3_reads: got %0d reads, required 3 reads at 0,1,2", rd_addrs.size());
        end
        checks++;
        if (wb_cnt != 3 || rw_cnt != 3 || exp_wb.size() != 0) begin
            errors++;
            $display("FAIL n3_counts: got wb %0d rw %0d pending %0d, required 3 3 0", wb_cnt, rw_cnt, exp_wb.size());
        end
        checks++;
        if (busy_first != 1 || busy_last != 16) begin
            errors++;
            $display("FAIL n3_busy: got %0d..%0d, required 1..16", busy_first, busy_last);
        end
        checks++;
        if (pktType !== PKT_HELLO || chosenHop !== ID_BASE + 16'd1 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL n3_hold: got type %0d hop %h err %b, required %0d %h 0",
                     pktType, chosenHop, done_err, PKT_HELLO, ID_BASE + 16'd1);
        end
    endtask

    task automatic test_timeout();
        rw_vals[0] = 16'd50; rw_vals[1] = 16'd70; rw_vals[2] = 16'd90;
        hang_addr = 1;
        do_start(5'd3, PKT_DATA);
        wait_done(200);
        checks++;
        if (done_cycle != 72 || done_cnt != 1) begin
            errors++;
            $display("FAIL to_done: got cycle %0d count %0d, required 72 1", done_cycle, done_cnt);
        end
        checks++;
        if (done_err !== 1'b1 || err !== 1'b1) begin
            errors++;
            $display("FAIL to_err: got %b/%b, required 1/1", done_err, err);
        end
        checks++;
        if (wb_cnt != 1 || last_wb_addr != 0 || rw_cnt != 2) begin
            errors++;
            $display("FAIL to_wb: got wb %0d last %0d rw %0d, required 1 0 2", wb_cnt, last_wb_addr, rw_cnt);
        end
        checks++;
        if (done_hop !== ID_BASE || done_q !== 16'd50 || done_valid !== 1'b1) begin
            errors++;
            $display("FAIL to_chosen: got hop %h q %0d v %b, required %h 50 1", done_hop, done_q, done_valid, ID_BASE);
        end
        hang_addr = -1;
    endtask

    task automatic test_zero_count();
        do_start(5'd0, PKT_ACK);
        wait_done(20);
        checks++;
        if (done_cycle != 1 || busy_last != 1 || rd_addrs.size() != 0) begin
            errors++;
            $display("FAIL n0_timing: got done %0d busy_last %0d reads %0d, required 1 1 0",
                     done_cycle, busy_last, rd_addrs.size());
        end
        checks++;
        if (done_valid !== 1'b0 || done_err !== 1'b0) begin
            errors++;
            $display("FAIL n0_status: got valid %b err %b, required 0 0", done_valid, done_err);
        end
    endtask

    task automatic test_clamp();
        int best = 0;
        bit order_ok = 1'b1;
        for (int i = 0; i < MAXN; i++) rw_vals[i] = 16'($urandom_range(0, 7));
        for (int i = 1; i < MAXN; i++) if (rw_vals[i] > rw_vals[best]) best = i;
        do_start(5'd20, PKT_ROUTE_REPLY);
        wait_done(200);
        for (int i = 0; i < rd_addrs.size(); i++) if (int'(rd_addrs[i]) != i) order_ok = 1'b0;
        checks++;
        if (rd_addrs.size() != 16 || !order_ok) begin
            errors++;
            $display("FAIL clamp_reads: got %0d reads in-order %b, required 16 in-order 1", rd_addrs.size(), order_ok);
        end
        checks++;
        if (last_wb_addr != 15 || wb_cnt != 16 || done_cycle != 81) begin
            errors++;
            $display("FAIL clamp_wb: got last %0d wb %0d done %0d, required 15 16 81", last_wb_addr, wb_cnt, done_cycle);
        end
        checks++;
        if (done_hop !== ID_BASE + 16'(best) || done_q !== rw_vals[best]) begin
            errors++;
            $display("FAIL clamp_best: got hop %h q %0d, required %h %0d",
                     done_hop, done_q, ID_BASE + 16'(best), rw_vals[best]);
        end
    endtask

    task automatic test_restart_and_reset();
        logic [65:0] outs;
        rw_vals[0] = 16'd1; rw_vals[1] = 16'd2; rw_vals[2] = 16'd3; rw_vals[3] = 16'd4;
        do_start(5'd4, PKT_ACK);
        while (edge_cnt - start_edge < 3) @(negedge clk);
        start = 1'b1; neighborCount = 5'd2; fPacketType = PKT_DATA;
        @(negedge clk);
        start = 1'b0;
        while (edge_cnt - start_edge < 13) @(negedge clk);
        checks++;
        if (bus.rw_start !== 1'b1 || pktType !== PKT_ACK) begin
            errors++;
            $display("FAIL rs_midscan: got rw_start %b type %0d, required 1 %0d", bus.rw_start, pktType, PKT_ACK);
        end
        checks++;
        if (rd_addrs.size() != 3 || rd_addrs[0] !== 4'd0 || rd_addrs[1] !== 4'd1 || rd_addrs[2] !== 4'd2 || wb_cnt != 2) begin
            errors++;
            $display("FAIL rs_ignored_start: got %0d reads %0d wb, required 3 reads 2 wb", rd_addrs.size(), wb_cnt);
        end
        nrst = 1'b0;
        @(negedge clk);
        outs = {busy, done, err, pktType, chosenValid, chosenHop, chosenQ, bus.nt_rd_en,
                bus.nt_rd_addr, bus.rw_start, bus.wb_en, bus.wb_addr, bus.wb_qvalue};
        checks++;
        if (outs !== '0) begin
            errors++;
            $display("FAIL rs_reset_outputs: got %h, required 0", outs);
        end
        @(negedge clk);
        nrst = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done_cnt != 0) begin
            errors++;
            $display("FAIL rs_idle: got busy %b dones %0d, required 0 0", busy, done_cnt);
        end
        exp_wb.delete();
        rw_vals[0] = 16'd7; rw_vals[1] = 16'd5;
        do_start(5'd2, PKT_ROUTE_REQ);
        wait_done(100);
        checks++;
        if (rd_addrs.size() < 1 || rd_addrs[0] !== 4'd0 || done_cycle != 11) begin
            errors++;
            $display("FAIL rs_restart: got first addr %0d done %0d, required 0 11", rd_addrs[0], done_cycle);
        end
        checks++;
        if (done_hop !== ID_BASE || done_q !== 16'd7 || exp_wb.size() != 0) begin
            errors++;
            $display("FAIL rs_chosen: got hop %h q %0d pending %0d, required %h 7 0",
                     done_hop, done_q, exp_wb.size(), ID_BASE);
        end
    endtask

    task automatic test_stray_delay();
        rw_vals[0] = 16'd100; rw_vals[1] = 16'd200;
        rd_delay = 5;
        stray_en = 1'b1;
        do_start(5'd2, PKT_HELLO);
        wait_done(100);
        checks++;
        if (done_cycle != 19 || busy_last != 19) begin
            errors++;
            $display("FAIL sd_timing: got done %0d busy_last %0d, required 19 19", done_cycle, busy_last);
        end
        checks++;
        if (done_hop !== ID_BASE + 16'd1 || done_q !== 16'd200 || wb_cnt != 2 || exp_wb.size() != 0) begin
            errors++;
            $display("FAIL sd_result: got hop %h q %0d wb %0d pending %0d, required %h 200 2 0",
                     done_hop, done_q, wb_cnt, exp_wb.size(), ID_BASE + 16'd1);
        end
        rd_delay = 1;
        stray_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MAXN; i++) rw_vals[i] = '0;
        test_reset();
        test_three_entries();
        test_timeout();
        test_zero_count();
        test_clamp();
        test_restart_and_reset();
        test_stray_delay();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Hard stop in case a scenario stalls somewhere unforeseen.
    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running, required completion");
        $fatal(1, "global timeout");
    end
endmodule
